instr_fetch_queue: RTL
======================

Name: instr_fetch_queue

Overview:
- Fetch stage directly downstream of program_counter.
- Issues sequential 16-bit instruction reads to instruction memory and buffers returned words with their addresses in a small FIFO.
- Presents the buffered words to decode over a valid/ready handshake.
- On a redirect (branch/jump), flushes the FIFO, restarts fetch at the target and emits a one-cycle load pulse (pc_ld_sig/pc_ld_in) that drives program_counter's ld_sig/ld_in.

Parameters:
- ADDR_W, 16, fetch address width (word addressed)
- DATA_W, 16, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 16'h0000, fetch address after reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- redirect  in  1  one-cycle flush/restart request
- redirect_addr  in  ADDR_W  restart address, sampled when redirect=1
- mem_req  out  1  read request, held until mem_ack
- mem_addr  out  ADDR_W  read address, stable while mem_req=1
- mem_ack  in  1  read done, mem_rdata valid this cycle
- mem_rdata  in  DATA_W  read data
- inst_valid  out  1  FIFO non-empty
- inst_data  out  DATA_W  FIFO head instruction
- inst_pc  out  ADDR_W  FIFO head address
- inst_ready  in  1  decode accepts head
- pc_ld_sig  out  1  one-cycle load strobe to program_counter
- pc_ld_in  out  ADDR_W  load value to program_counter

Behaviour:
- Reset (rst=0, async):
  - State = IDLE.
  - fetch_addr = RESET_PC.
  - FIFO empty (count 0, pointers 0).
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, pc_ld_sig=0, pc_ld_in=0.
- FSM states: IDLE, REQ, DRAIN.
  - IDLE: mem_req=0. Go to REQ when count + 0 < DEPTH and no redirect this cycle.
  - REQ: mem_req=1, mem_addr=fetch_addr.
    - On mem_ack without redirect: push {fetch_addr, mem_rdata}, fetch_addr += 1.
    - After that push, stay in REQ if space remains for another word, else go to IDLE.
  - DRAIN: mem_req=1, holding the old mem_addr. On mem_ack, discard data and go to IDLE.
- Space rule: a request is issued only if the FIFO has at least one free slot for it. Only one request is outstanding; it always fits, so no overflow occurs.
- Address arithmetic: modulo 2^ADDR_W; 16'hFFFF + 1 wraps to 16'h0000 with no flag.
- Latency:
  - Minimum 1 cycle from mem_ack to inst_valid=1; the FIFO write registers on the ack edge.
  - First mem_req asserts on the cycle after reset release.
- Pop: when inst_valid & inst_ready, the head is removed on the clock edge. Push and pop in the same cycle leave count unchanged. Pop is legal when the FIFO is full.
- Empty: inst_valid=0. inst_data and inst_pc hold their last values and are don't-care.
- Redirect:
  - On the edge where redirect=1: FIFO flushed (count 0), fetch_addr = redirect_addr, pc_ld_sig=1, pc_ld_in=redirect_addr for exactly one cycle.
  - Pop in the same cycle is ignored; flush wins.
  - A mem_ack arriving in the same cycle is discarded; state goes to IDLE.
  - Redirect in REQ without ack: state → DRAIN, mem_req stays high until ack, then that data is discarded.
  - Redirect in IDLE: stay IDLE; fetch resumes next cycle from redirect_addr.
  - Redirect in DRAIN: update fetch_addr and pulse pc_ld again; remain in DRAIN.
- mem_addr must not change while mem_req=1, even across a redirect.
- Reset mid-transaction: immediate return to reset values. Any late mem_ack while in IDLE after reset is ignored.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments every cycle with mem_req=1 & mem_ack=0, saturating at 16'hFFFF.
  - Cleared by reset only; not cleared by redirect.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset release, mem_ack one cycle after every mem_req, inst_ready=1 → mem_addr 0,1,2,3… with mem_req held continuously. inst_pc/inst_data follow mem_addr/mem_rdata one cycle later. pc_ld_sig stays 0.
- inst_ready=0, DEPTH=4 → exactly 4 words stored (addrs 0..3), then mem_req=0 and FSM in IDLE. After one inst_ready pulse, inst_pc=0 is popped, exactly one more request (addr 4) issues, and count returns to 4.
- Redirect to 16'h0020 while FIFO holds 3 entries and no request is outstanding → next cycle inst_valid=0, pc_ld_sig=1 for one cycle with pc_ld_in=16'h0020, and the next mem_addr is 16'h0020.
- Redirect to 16'h0040 while the request for addr 5 is pending, with ack 3 cycles later → mem_addr stays 5 until ack, the addr-5 data never appears on inst_*, and the next request is 16'h0040.
- RESET_PC=16'hFFFE, acks immediate → mem_addr sequence FFFE, FFFF, 0000, 0001. Then assert rst=0 mid-request → mem_req=0 and inst_valid=0 immediately, without waiting for a clock edge.
- With FETCH_STALL_CNT_EN, acks delayed by 3 cycles for 2 requests → stall_cnt=6. Redirect leaves it unchanged; reset clears it to 0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: sequential reads into a small FIFO, valid/ready delivery to decode.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module instr_fetch_queue #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              pc_ld_sig,
  output logic [ADDR_W-1:0] pc_ld_in
);

  localparam int unsigned     PtrW   = $clog2(DEPTH);
  localparam int unsigned     CntW   = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              pc_ld_sig_q;
  logic [ADDR_W-1:0] pc_ld_in_q;
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic              push, pop;

  always_comb begin
    // A redirect discards any same-cycle ack and blocks pops.
    push    = (state_q == StReq) && mem_ack && !redirect;
    pop     = (count_q != '0) && inst_ready && !redirect;
    count_d = count_q + CntW'(push) - CntW'(pop);

    fetch_addr_d = fetch_addr_q;
    if (redirect) begin
      fetch_addr_d = redirect_addr;
    end else if (push) begin
      fetch_addr_d = fetch_addr_q + ADDR_W'(1);
    end

    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!redirect && (count_q < DepthC)) state_d = StReq;
      end
      StReq: begin
        if (mem_ack) begin
          state_d = (!redirect && (count_d < DepthC)) ? StReq : StIdle;
        end else if (redirect) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      fetch_addr_q <= RESET_PC;
      mem_addr_q   <= RESET_PC;
      pc_ld_sig_q  <= 1'b0;
      pc_ld_in_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      data_q       <= '{default: '0};
      pc_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      // The outstanding address must stay put while a discarded read drains.
      if (state_d != StDrain) mem_addr_q <= fetch_addr_d;
      pc_ld_sig_q  <= redirect;
      pc_ld_in_q   <= redirect ? redirect_addr : '0;
      if (redirect) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        count_q <= count_d;
        if (push) begin
          data_q[wr_ptr_q] <= mem_rdata;
          pc_q[wr_ptr_q]   <= fetch_addr_q;
          wr_ptr_q         <= wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (mem_req && !mem_ack && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign mem_req    = (state_q != StIdle);
  assign mem_addr   = mem_addr_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = data_q[rd_ptr_q];
  assign inst_pc    = pc_q[rd_ptr_q];
  assign pc_ld_sig  = pc_ld_sig_q;
  assign pc_ld_in   = pc_ld_in_q;

endmodule
